dmem_store_buffer: RTL

Posted-write store buffer between the memory stage and the data-memory bus. Accepts byte-strobed store requests (address, lane-replicated data, strobe) in one cycle and holds them in an in-order FIFO. Drains them to a req/ack bus with timeout and error capture. Reports read-after-write hazards to loads and drain status for fences.

---
 rtl/dmem_store_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer: in-order FIFO of byte-strobed stores drained to a req/ack bus,
// with timeout/error capture, load hazard detection and a drained flag for fences.
module dmem_store_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_strb,
  output logic                     st_ready,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  input  logic                     fence_req,
  output logic                     drained,
  output logic                     bus_req,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wdata,
  output logic [3:0]               bus_strb,
  input  logic                     bus_ack,
  input  logic                     bus_err,
  output logic                     err_valid,
  output logic [31:0]              err_addr,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StErr} state_e;

  logic [29:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [3:0]    mem_strb [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, nxt_idx;
  logic [15:0]   timer_q, timer_inc;
  state_e        state_q;

  logic        push, ack_ok, timeout_hit, fail, pop, rem_old, more;
  logic [29:0] nh_addr;
  logic [31:0] nh_data;
  logic [3:0]  nh_strb;

  assign st_ready    = (count != CW'(DEPTH));
  assign drained     = (count == '0) && (state_q == StIdle);
  assign push        = st_valid && st_ready && (st_strb != 4'b0000);
  assign timer_inc   = timer_q + 16'd1;
  assign ack_ok      = (state_q == StReq) && bus_ack && !bus_err;
  assign timeout_hit = (state_q == StReq) && !bus_ack && (timer_inc == 16'(TIMEOUT));
  assign fail        = (state_q == StReq) && ((bus_ack && bus_err) || timeout_hit);
  assign pop         = ack_ok || fail;

  // Next head after a successful pop; bypass the incoming store if it is the only one left.
  assign nxt_idx = rd_ptr_q + 1'b1;
  assign rem_old = (count != CW'(1));
  assign more    = rem_old || push;
  assign nh_addr = rem_old ? mem_addr[nxt_idx] : st_addr[31:2];
  assign nh_data = rem_old ? mem_data[nxt_idx] : st_data;
  assign nh_strb = rem_old ? mem_strb[nxt_idx] : st_strb;

  always_comb begin
    logic [PW-1:0] off;
    off       = '0;
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count) && (mem_addr[i] == ld_addr[31:2])) ld_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= st_addr[31:2];
      mem_data[wr_ptr_q] <= st_data;
      mem_strb[wr_ptr_q] <= st_strb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count     <= '0;
      state_q   <= StIdle;
      timer_q   <= '0;
      bus_req   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_strb  <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      // A new error takes priority over a same-cycle clear.
      if (fail) begin
        err_valid <= 1'b1;
        err_addr  <= bus_addr;
      end else if (err_clr) begin
        err_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (count != '0) begin
            state_q   <= StReq;
            bus_req   <= 1'b1;
            bus_addr  <= {mem_addr[rd_ptr_q], 2'b00};
            bus_wdata <= mem_data[rd_ptr_q];
            bus_strb  <= mem_strb[rd_ptr_q];
            timer_q   <= '0;
          end
        end
        StReq: begin
          if (fail) begin
            state_q <= StErr;
            bus_req <= 1'b0;
            timer_q <= '0;
          end else if (ack_ok) begin
            timer_q <= '0;
            if (more) begin
              bus_addr  <= {nh_addr, 2'b00};
              bus_wdata <= nh_data;
              bus_strb  <= nh_strb;
            end else begin
              state_q <= StIdle;
              bus_req <= 1'b0;
            end
          end else if (timer_q != 16'hFFFF) begin
            timer_q <= timer_inc;
          end
        end
        StErr: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
